// File: rtl/puf_uart_pkg.sv
// Shared definitions for the PUF-to-UART framing path: framer states,
// frame geometry and the sync byte the host-side decoder looks for.
package puf_uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } framer_state_t;

  // Sync + 8 data bytes + checksum.
  localparam int FRAME_LEN_MAX = 10;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // XOR of the eight bytes of a response word (the frame checksum).
  function automatic logic [7:0] xor_fold64(input logic [63:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ word[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/puf_tx_framer.sv
// Frames one 64-bit PUF response into sync / 8 data bytes (MSB first) /
// optional XOR checksum and hands the bytes one at a time to a UART
// transmitter, pacing on its busy flag.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready for a response, no frame in progress
// SEND       | strobe transmit for the byte selected by r_idx
// WAIT_START | waiting for the UART to raise is_transmitting (timed)
// WAIT_DONE  | UART busy with the current byte
// GAP        | idle spacing after a byte, then next byte or frame end
module puf_tx_framer
  import puf_uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE        = SYNC_BYTE_DEFAULT,
  parameter bit         INCLUDE_CHECKSUM = 1'b1,
  parameter int         GAP_CYCLES       = 2,
  parameter int         START_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        resp_ready,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(START_TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [3:0]    LAST_IDX = INCLUDE_CHECKSUM ? 4'(FRAME_LEN_MAX - 1)
                                                        : 4'(FRAME_LEN_MAX - 2);

  framer_state_t r_state;
  framer_state_t w_state_nxt;

  logic [63:0]   r_shift;
  logic [7:0]    r_csum;
  logic [3:0]    r_idx;
  logic [GW-1:0] r_gap_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_tx_byte;

  logic w_accept;
  logic w_gap_end;
  logic w_step;

  // Next-state decode and strobe/pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_gap_end   = 1'b0;
    w_step      = 1'b0;
    resp_ready  = 1'b0;
    transmit    = 1'b0;
    frame_done  = 1'b0;
    frame_error = 1'b0;

    case (r_state)
      IDLE: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        transmit = 1'b1;
        // A UART already busy in the strobe cycle is taken as started.
        w_state_nxt = is_transmitting ? WAIT_DONE : WAIT_START;
      end
      WAIT_START: begin
        if (is_transmitting) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_to_cnt >= TO_LAST) begin
          frame_error = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          // With no spacing requested the GAP state is skipped entirely.
          if (GAP_CYCLES == 0) begin
            w_gap_end = 1'b1;
          end else begin
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt <= GW'(1)) begin
          w_gap_end = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_gap_end) begin
      if (r_idx == LAST_IDX) begin
        frame_done  = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_step      = 1'b1;
        w_state_nxt = SEND;
      end
    end

    // An abort by reset never reports completion or error.
    if (rst) begin
      frame_done  = 1'b0;
      frame_error = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response latch, byte index and the byte mux feeding tx_byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= 64'd0;
      r_csum    <= 8'h00;
      r_idx     <= 4'd0;
      r_tx_byte <= 8'h00;
    end else if (w_accept) begin
      r_shift   <= resp_data;
      r_csum    <= xor_fold64(resp_data);
      r_idx     <= 4'd0;
      r_tx_byte <= SYNC_BYTE;
    end else if (w_step) begin
      r_idx <= r_idx + 4'd1;
      if (r_idx < 4'd8) begin
        r_tx_byte <= r_shift[63:56];
        r_shift   <= {r_shift[55:0], 8'h00};
      end else begin
        r_tx_byte <= r_csum;
      end
    end
  end

  // Start-timeout counter: cleared at each strobe, saturating count-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == SEND) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT_START && r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Inter-byte gap counter: loaded when the UART goes idle, counts down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (r_state == WAIT_DONE && !is_transmitting) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (r_state == GAP && r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - GW'(1);
    end
  end

  assign busy    = (r_state != IDLE);
  assign tx_byte = r_tx_byte;

endmodule

// File: tb/tb_puf_tx_framer.sv
// Self-checking bench for puf_tx_framer: UART busy model, output monitor,
// and a frame reference model built from the framing rules.
module tb_puf_tx_framer;

  localparam int UART_BUSY = 20;
  localparam int GAP       = 2;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_ready;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_tx = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        frame_error;

  logic        nc_valid;
  logic [63:0] nc_data;
  logic        nc_ready;
  logic [7:0]  nc_tx_byte;
  logic        nc_transmit;
  logic        nc_is_tx = 1'b0;
  logic        nc_busy;
  logic        nc_done;
  logic        nc_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  puf_tx_framer #(
    .SYNC_BYTE(8'hA5), .INCLUDE_CHECKSUM(1'b1), .GAP_CYCLES(GAP), .START_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .tx_byte(tx_byte), .transmit(transmit),
    .is_transmitting(is_tx), .busy(busy), .frame_done(frame_done),
    .frame_error(frame_error)
  );

  puf_tx_framer #(
    .SYNC_BYTE(8'hA5), .INCLUDE_CHECKSUM(1'b0), .GAP_CYCLES(GAP), .START_TIMEOUT(TIMEOUT)
  ) dut_nc (
    .clk(clk), .rst(rst), .resp_valid(nc_valid), .resp_data(nc_data),
    .resp_ready(nc_ready), .tx_byte(nc_tx_byte), .transmit(nc_transmit),
    .is_transmitting(nc_is_tx), .busy(nc_busy), .frame_done(nc_done),
    .frame_error(nc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART models: busy for UART_BUSY cycles starting the cycle after a strobe.
  int ua_left = 0;
  bit ua_dead = 1'b0;
  always @(posedge clk) begin
    if (ua_left > 0) begin
      ua_left <= ua_left - 1;
      is_tx   <= (ua_left > 1);
    end else if (transmit && !ua_dead) begin
      is_tx   <= 1'b1;
      ua_left <= UART_BUSY;
    end
  end

  int nc_left = 0;
  always @(posedge clk) begin
    if (nc_left > 0) begin
      nc_left  <= nc_left - 1;
      nc_is_tx <= (nc_left > 1);
    end else if (nc_transmit) begin
      nc_is_tx <= 1'b1;
      nc_left  <= UART_BUSY;
    end
  end

  // Monitor: record strobed bytes, strobe/fall cycles and pulses.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] nc_q[$];
  int strobe_cyc[$];
  int fall_cyc[$];
  int overlap_cnt = 0;
  int stab_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int nc_done_cnt = 0;
  logic prev_is_tx = 1'b0;
  logic [7:0] last_tx = 8'h00;

  always @(negedge clk) begin
    if (transmit) begin
      got_q.push_back(tx_byte);
      strobe_cyc.push_back(cyc);
      last_tx = tx_byte;
    end else if (busy && got_q.size() > 0 && tx_byte !== last_tx) begin
      stab_err++;
    end
    if (transmit && is_tx) overlap_cnt++;
    if (prev_is_tx && !is_tx) fall_cyc.push_back(cyc);
    prev_is_tx = is_tx;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (nc_transmit) nc_q.push_back(nc_tx_byte);
    if (nc_done) nc_done_cnt++;
  end

  // Reference frame: sync, bytes MSB first, optional XOR of the data bytes.
  function automatic void model_frame(input logic [63:0] d, input bit with_csum);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      b = d[i*8 +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    if (with_csum) exp_q.push_back(c);
  endfunction

  function automatic int first_diff(input bit use_nc);
    if (use_nc) begin
      if (nc_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (nc_q[i] !== exp_q[i]) return i;
    end else begin
      if (got_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  // Count strobes not landing exactly GAP+1 cycles after the previous byte's fall.
  function automatic int pacing_bad();
    int bad;
    bad = 0;
    for (int k = 1; k < strobe_cyc.size(); k++) begin
      if (k - 1 >= fall_cyc.size()) bad++;
      else if (strobe_cyc[k] - fall_cyc[k-1] != GAP + 1) bad++;
    end
    return bad;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    strobe_cyc.delete();
    fall_cyc.delete();
    overlap_cnt = 0;
    stab_err = 0;
  endtask

  task automatic drive_one(input logic [63:0] d, output bit ok);
    bit acc;
    ok = 1'b0;
    resp_valid = 1'b1;
    resp_data = d;
    for (int i = 0; i < 600; i++) begin
      acc = resp_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    resp_valid = 1'b0;
  endtask

  task automatic wait_frame_end(input int budget, output bit ok);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0 || err_cnt != e0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_valid = 1'b0;
    resp_data = 64'd0;
    nc_valid = 1'b0;
    nc_data = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL reset_resp_ready got=%b exp=1", resp_ready); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got=%b exp=0", transmit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL reset_pulses done=%b err=%b exp=0,0", frame_done, frame_error); end
    checks++; if (nc_ready !== 1'b1 || nc_busy !== 1'b0) begin errors++; $display("FAIL reset_nc ready=%b busy=%b exp=1,0", nc_ready, nc_busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_frame_content(input logic [63:0] d, input string tag);
    bit ok;
    int d0;
    int e0;
    int df;
    clear_mon();
    model_frame(d, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    drive_one(d, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept timed out waiting for resp_ready", tag); end
    wait_frame_end(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_end timed out waiting for frame end", tag); end
    df = first_diff(1'b0);
    checks++; if (df != -1) begin errors++; $display("FAIL %s_bytes diff_at=%0d got_len=%0d exp_len=%0d", tag, df, got_q.size(), exp_q.size()); end
    checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin errors++; $display("FAIL %s_pulses done=%0d err=%0d exp=1,0", tag, done_cnt - d0, err_cnt - e0); end
    checks++; if (pacing_bad() != 0) begin errors++; $display("FAIL %s_pacing bad_gaps=%0d exp=0", tag, pacing_bad()); end
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL %s_overlap strobes_while_busy=%0d exp=0", tag, overlap_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL %s_tx_stable changes=%0d exp=0", tag, stab_err); end
    @(negedge clk);
    checks++; if (resp_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_ready_after_done ready=%b busy=%b exp=1,0", tag, resp_ready, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_checksum_off();
    bit ok;
    bit acc;
    int df;
    nc_q.delete();
    model_frame(64'hFF00000000000001, 1'b0);
    nc_valid = 1'b1;
    nc_data = 64'hFF00000000000001;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = nc_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    nc_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL nocsum_accept timed out"); end
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (nc_done_cnt != 0) begin ok = 1'b1; break; end
    end
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL nocsum_end timed out waiting for frame_done"); end
    df = first_diff(1'b1);
    checks++; if (df != -1) begin errors++; $display("FAIL nocsum_bytes diff_at=%0d got_len=%0d exp_len=9", df, nc_q.size()); end
    test_frame_content(64'hFF00000000000001, "csum_on");
    checks++; if (got_q.size() < 10 || got_q[got_q.size()-1] !== 8'hFE) begin errors++; $display("FAIL csum_byte got_len=%0d exp_last=FE", got_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0;
    int e0;
    clear_mon();
    ua_dead = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_one({$urandom, $urandom}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_accept timed out"); end
    wait_frame_end(100, ok);
    checks++; if (!ok || err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_error err_pulses=%0d exp=1", err_cnt - e0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL timeout_no_done done_pulses=%0d exp=0", done_cnt - d0); end
    checks++; if (strobe_cyc.size() != 1 || err_cyc - strobe_cyc[0] != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycle strobes=%0d delay=%0d exp=1,%0d", strobe_cyc.size(),
               (strobe_cyc.size() > 0) ? err_cyc - strobe_cyc[0] : -1, TIMEOUT);
    end
    @(negedge clk);
    checks++; if (resp_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_ready ready=%b busy=%b exp=1,0", resp_ready, busy); end
    ua_dead = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int d0;
    int e0;
    clear_mon();
    d0 = done_cnt;
    e0 = err_cnt;
    drive_one({$urandom, $urandom}, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (got_q.size() >= 5) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_reach_byte4 strobes=%0d exp>=5", got_q.size()); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (transmit !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle transmit=%b busy=%b exp=0,0", transmit, busy); end
    checks++; if (tx_byte !== 8'h00 || resp_ready !== 1'b1) begin errors++; $display("FAIL midrst_outputs tx_byte=%h ready=%b exp=00,1", tx_byte, resp_ready); end
    repeat (30) @(posedge clk);
    checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL midrst_no_pulse done=%0d err=%0d exp=0,0", done_cnt - d0, err_cnt - e0); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (!is_tx) begin ok = 1'b1; break; end
    end
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL midrst_uart_idle is_transmitting stuck high"); end
    test_frame_content({$urandom, $urandom}, "post_reset");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int df;
    int done1;
    logic [63:0] d1;
    logic [63:0] d2;
    d1 = {$urandom, $urandom};
    d2 = ~d1 ^ {32'h0, $urandom};
    clear_mon();
    resp_data = d1;
    resp_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (got_q.size() >= 1) begin ok = 1'b1; break; end
    end
    #1;
    resp_data = d2;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_strobe timed out"); end
    wait_frame_end(1000, ok);
    done1 = done_cyc;
    model_frame(d1, 1'b1);
    df = first_diff(1'b0);
    checks++; if (!ok || df != -1) begin errors++; $display("FAIL b2b_frame1 ended=%0b diff_at=%0d got_len=%0d", ok, df, got_q.size()); end
    clear_mon();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (got_q.size() >= 1) begin ok = 1'b1; break; end
    end
    #1;
    resp_valid = 1'b0;
    checks++; if (!ok || strobe_cyc[0] != done1 + 2) begin
      errors++;
      $display("FAIL b2b_frame2_start strobe_cyc=%0d exp=%0d", ok ? strobe_cyc[0] : -1, done1 + 2);
    end
    wait_frame_end(1000, ok);
    model_frame(d2, 1'b1);
    df = first_diff(1'b0);
    checks++; if (!ok || df != -1) begin errors++; $display("FAIL b2b_frame2 ended=%0b diff_at=%0d got_len=%0d", ok, df, got_q.size()); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third_frame busy=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_frame_content(64'h0123456789ABCDEF, "fixed");
    for (int n = 0; n < 3; n++) test_frame_content({$urandom, $urandom}, "random");
    test_checksum_off();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
